// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch unit's control, instruction-memory and IF/ID signals.
// The master side is the fetch unit. The slave side is its environment:
// the hazard unit, EXE, instruction memory and the IF/ID register.
interface if_fetch_unit_if;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        if_valid;
   logic        flush_out;

   modport master (
      input  freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
      output imem_req, imem_addr, pc_out, instruction_out, if_valid, flush_out
   );

   modport slave (
      output freeze, branch_taken, branch_addr, imem_ready, imem_rdata,
      input  imem_req, imem_addr, pc_out, instruction_out, if_valid, flush_out
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. It owns the PC and keeps at most one request
// outstanding to variable-latency instruction memory. A returned word is
// delivered combinationally in its ready cycle. If the pipeline is frozen,
// the word is parked in ibuf instead. A branch that arrives while a request
// is still in flight makes the unit drain that request first, so the
// memory sees its address held stable until ready.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   if_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ibuf_q, ibuf_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   // State register, PC, captured word and the address of a request being drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         ibuf_q       <= 32'h0;
         drain_addr_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ibuf_q       <= ibuf_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   // Next-state and output decode. The outputs default to a bubble, and
   // everything is forced to zero while reset is held.
   always_comb begin
      state_d             = state_q;
      pc_d                = pc_q;
      ibuf_d              = ibuf_q;
      drain_addr_d        = drain_addr_q;
      bus.imem_req        = 1'b0;
      bus.imem_addr       = 32'h0;
      bus.pc_out          = 32'h0;
      bus.instruction_out = 32'h0;
      bus.if_valid        = 1'b0;
      bus.flush_out       = 1'b0;

      if (!rst) begin
         bus.flush_out = bus.branch_taken;
         case (state_q)
            FETCH: begin
               bus.imem_req  = 1'b1;
               bus.imem_addr = pc_q;
               if (bus.branch_taken) begin
                  // Redirect. An in-flight request must still complete,
                  // so park its address and drain it.
                  pc_d = bus.branch_addr;
                  if (!bus.imem_ready) begin
                     drain_addr_d = pc_q;
                     state_d      = DRAIN;
                  end
               end else if (bus.imem_ready) begin
                  if (!bus.freeze) begin
                     bus.instruction_out = bus.imem_rdata;
                     bus.pc_out          = pc_plus4;
                     bus.if_valid        = 1'b1;
                     pc_d                = pc_plus4;
                  end else begin
                     ibuf_d  = bus.imem_rdata;
                     state_d = HOLD;
                  end
               end
            end

            HOLD: begin
               // The word is already in ibuf. No request until it leaves.
               if (bus.branch_taken) begin
                  pc_d    = bus.branch_addr;
                  state_d = FETCH;
               end else if (!bus.freeze) begin
                  bus.instruction_out = ibuf_q;
                  bus.pc_out          = pc_plus4;
                  bus.if_valid        = 1'b1;
                  pc_d                = pc_plus4;
                  state_d             = FETCH;
               end
            end

            DRAIN: begin
               // Keep the abandoned request alive until memory answers.
               // A later branch simply overrides the target.
               bus.imem_req  = 1'b1;
               bus.imem_addr = drain_addr_q;
               if (bus.branch_taken) begin
                  pc_d = bus.branch_addr;
               end
               if (bus.imem_ready) begin
                  state_d = FETCH;
               end
            end

            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. A behavioural model (pc, an optional parked word,
// an optional pending drain) predicts the outputs in every cycle. Directed
// literal checks pin the model to known sequences. A random phase then
// exercises freezes, branches, resets and memory latency together.
module tb_if_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   if_fetch_unit_if bus ();

   if_fetch_unit #(.RESET_PC(RPC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model: the latency is chosen when a request first appears. A
   // reset abandons whatever is in flight.
   logic        m_busy = 1'b0;
   int          m_cnt  = 0;
   logic        m_fire = 1'b0;

   // Advance one cycle: apply the inputs after the edge, then answer memory.
   task automatic cyc(input logic r, input logic frz, input logic bt,
                      input logic [31:0] ba, input int lat);
      @(posedge clk);
      #1;
      if (m_fire) m_busy = 1'b0;
      else if (m_busy && m_cnt > 0) m_cnt--;
      rst              = r;
      bus.freeze       = frz;
      bus.branch_taken = bt;
      bus.branch_addr  = ba;
      if (r) m_busy = 1'b0;
      #1;
      if (bus.imem_req && !m_busy) begin
         m_busy = 1'b1;
         m_cnt  = lat;
      end
      bus.imem_ready = bus.imem_req && m_busy && (m_cnt == 0);
      bus.imem_rdata = bus.imem_ready ? (bus.imem_addr ^ KEY) : $urandom;
      m_fire         = bus.imem_ready;
      #1;
   endtask

   // Behavioural model state.
   logic [31:0] md_pc;
   logic        md_held_v;
   logic [31:0] md_held;
   logic        md_drain_v;
   logic [31:0] md_drain_a;

   // Every cycle: predict the outputs from the model and the current
   // inputs, compare them with the DUT, then advance the model.
   always @(negedge clk) begin
      logic        e_req, e_v, e_fl;
      logic [31:0] e_addr, e_pc, e_ins, w;
      logic        dlv;
      e_req = 1'b0; e_v = 1'b0; e_fl = 1'b0;
      e_addr = 32'h0; e_pc = 32'h0; e_ins = 32'h0; w = 32'h0; dlv = 1'b0;
      if (rst) begin
         md_pc = RPC; md_held_v = 1'b0; md_held = 32'h0;
         md_drain_v = 1'b0; md_drain_a = 32'h0;
      end else begin
         e_fl   = bus.branch_taken;
         e_req  = !md_held_v;
         e_addr = md_held_v ? 32'h0 : (md_drain_v ? md_drain_a : md_pc);
         if (md_held_v) begin
            if (bus.branch_taken) begin
               md_held_v = 1'b0; md_pc = bus.branch_addr;
            end else if (!bus.freeze) begin
               dlv = 1'b1; w = md_held; md_held_v = 1'b0;
            end
         end else if (md_drain_v) begin
            if (bus.branch_taken) md_pc = bus.branch_addr;
            if (bus.imem_ready) md_drain_v = 1'b0;
         end else if (bus.branch_taken) begin
            if (!bus.imem_ready) begin
               md_drain_v = 1'b1; md_drain_a = md_pc;
            end
            md_pc = bus.branch_addr;
         end else if (bus.imem_ready) begin
            if (!bus.freeze) begin
               dlv = 1'b1; w = bus.imem_rdata;
            end else begin
               md_held_v = 1'b1; md_held = bus.imem_rdata;
            end
         end
         if (dlv) begin
            e_v = 1'b1; e_ins = w; e_pc = md_pc + 32'd4; md_pc = md_pc + 32'd4;
         end
      end
      chk("m_req",   {31'h0, bus.imem_req},  {31'h0, e_req});
      if (e_req) chk("m_addr", bus.imem_addr, e_addr);
      chk("m_valid", {31'h0, bus.if_valid},  {31'h0, e_v});
      chk("m_pc",    bus.pc_out,             e_pc);
      chk("m_instr", bus.instruction_out,    e_ins);
      chk("m_flush", {31'h0, bus.flush_out}, {31'h0, e_fl});
   end

   initial begin
      bus.freeze       = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_addr  = 32'h0;
      bus.imem_ready   = 1'b0;
      bus.imem_rdata   = 32'h0;

      // Reset: everything is quiet, even with a branch asserted.
      cyc(1, 0, 1, 32'h0, 0);
      chk("rst_req",   {31'h0, bus.imem_req},  32'h0);
      chk("rst_flush", {31'h0, bus.flush_out}, 32'h0);
      chk("rst_pc",    bus.pc_out,             32'h0);
      cyc(1, 0, 0, 32'h0, 0);

      // Zero-wait streaming from RESET_PC.
      cyc(0, 0, 0, 32'h0, 0);
      chk("s0_addr", bus.imem_addr, 32'h100);
      chk("s0_pc",   bus.pc_out, 32'h104);
      chk("s0_ins",  bus.instruction_out, 32'hA5A5_0100);
      cyc(0, 0, 0, 32'h0, 0);
      chk("s1_addr", bus.imem_addr, 32'h104);
      chk("s1_pc",   bus.pc_out, 32'h108);
      cyc(0, 0, 0, 32'h0, 0);
      chk("s2_addr", bus.imem_addr, 32'h108);

      // Redirect to 0 with the word at 0x10C being discarded, then a 3-wait fetch.
      cyc(0, 0, 1, 32'h0, 0);
      chk("br0_valid", {31'h0, bus.if_valid}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 32'h0, 3);
         chk("w_addr",  bus.imem_addr, 32'h0);
         chk("w_req",   {31'h0, bus.imem_req}, 32'h1);
         chk("w_valid", {31'h0, bus.if_valid}, 32'h0);
      end
      cyc(0, 0, 0, 32'h0, 3);
      chk("w_pc", bus.pc_out, 32'h4);

      // Freeze across the ready cycle at 0x8.
      cyc(0, 0, 0, 32'h0, 0);
      cyc(0, 1, 0, 32'h0, 0);
      chk("fz_addr",  bus.imem_addr, 32'h8);
      chk("fz_valid", {31'h0, bus.if_valid}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 32'h0, 0);
         chk("fz_req", {31'h0, bus.imem_req}, 32'h0);
      end
      cyc(0, 0, 0, 32'h0, 0);
      chk("fz_pc",  bus.pc_out, 32'hC);
      chk("fz_ins", bus.instruction_out, 32'hA5A5_0008);
      cyc(0, 0, 0, 32'h0, 0);
      chk("fz_next", bus.imem_addr, 32'hC);

      // Branch while 0x10 is outstanding, with ready arriving 2 cycles later.
      cyc(0, 0, 1, 32'h400, 2);
      chk("dr_flush", {31'h0, bus.flush_out}, 32'h1);
      cyc(0, 0, 0, 32'h0, 2);
      chk("dr_flush1", {31'h0, bus.flush_out}, 32'h0);
      chk("dr_addr",   bus.imem_addr, 32'h10);
      cyc(0, 0, 0, 32'h0, 2);
      chk("dr_addr2", bus.imem_addr, 32'h10);
      chk("dr_drop",  {31'h0, bus.if_valid}, 32'h0);
      cyc(0, 0, 0, 32'h0, 0);
      chk("dr_tgt", bus.imem_addr, 32'h400);
      chk("dr_pc",  bus.pc_out, 32'h404);

      // Branch together with freeze while a word is parked.
      cyc(0, 1, 0, 32'h0, 0);
      cyc(0, 1, 1, 32'h800, 0);
      chk("hb_flush", {31'h0, bus.flush_out}, 32'h1);
      chk("hb_valid", {31'h0, bus.if_valid}, 32'h0);
      cyc(0, 0, 0, 32'h0, 3);
      chk("hb_addr", bus.imem_addr, 32'h800);

      // Reset in the middle of a drain.
      cyc(0, 0, 1, 32'hC00, 3);
      cyc(1, 0, 1, 32'h0, 0);
      chk("rd_req",   {31'h0, bus.imem_req},  32'h0);
      chk("rd_flush", {31'h0, bus.flush_out}, 32'h0);
      cyc(0, 0, 0, 32'h0, 0);
      chk("rd_addr", bus.imem_addr, 32'h100);

      // PC wrap.
      cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
      cyc(0, 0, 0, 32'h0, 0);
      chk("wr_pc",  bus.pc_out, 32'h0);
      chk("wr_ins", bus.instruction_out, 32'h5A5A_FFFC);
      cyc(0, 0, 0, 32'h0, 0);
      chk("wr_next", bus.imem_addr, 32'h0);

      // Random mix.
      for (int i = 0; i < 3000; i++) begin
         logic        r, f, b;
         logic [31:0] a;
         r = ($urandom_range(63) == 0);
         f = ($urandom_range(2) == 0);
         b = ($urandom_range(7) == 0);
         a = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         cyc(r, f, b, a, int'($urandom_range(3)));
      end

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that produces the PC/instruction pair consumed by the IF/ID pipeline register.
- Owns the program counter and drives a valid/ready handshake to instruction memory, which may have variable latency.
- Presents a bubble (all zeros) when no instruction is ready.
- Honours the hazard-unit freeze, redirects on taken branches from EXE, and generates the IF/ID flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  hazard stall; IF/ID holds and this block must not advance
- branch_taken  in  1  taken branch/jump resolved in EXE
- branch_addr  in  32  branch target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  in  32  fetched word, valid when imem_ready=1
- pc_out  out  32  PC+4 of the delivered instruction, else 0
- instruction_out  out  32  delivered instruction, else 0 (NOP)
- if_valid  out  1  a real instruction is presented this cycle
- flush_out  out  1  flush request to IF/ID; equals branch_taken

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC, ibuf=0, drain_addr=0.
- While rst=1, all outputs are 0, including imem_req.
- Reset mid-transaction abandons any outstanding request with no drain. The memory model must tolerate this.
- One outstanding request at most. Once asserted, imem_req and imem_addr stay fixed until imem_ready.
- Default outputs each cycle: pc_out=0, instruction_out=0, if_valid=0 (bubble). flush_out=branch_taken in every state.
- Delivery cycle:
  - instruction_out = the word.
  - pc_out = pc+4, mod 2^32; wrap from 32'hFFFF_FFFC to 0 is allowed.
  - if_valid=1.
  - pc advances to pc+4 at the next edge.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - branch_taken=1: pc<=branch_addr. Outputs stay bubble. If imem_ready=1, the returned word is discarded and the state stays FETCH. Otherwise drain_addr<=pc and the state goes to DRAIN.
    - Else imem_ready=1, freeze=0: deliver imem_rdata combinationally in the same cycle. Stay FETCH; the next request issues the following cycle at pc+4.
    - Else imem_ready=1, freeze=1: ibuf<=imem_rdata, go to HOLD.
    - Else (imem_ready=0): wait. freeze has no effect.
  - HOLD: imem_req=0.
    - branch_taken=1: discard ibuf, pc<=branch_addr, go to FETCH.
    - Else freeze=0: deliver ibuf, go to FETCH.
    - Else: stay HOLD.
  - DRAIN: imem_req=1, imem_addr=drain_addr. Outputs stay bubble.
    - branch_taken=1: pc<=branch_addr, stay DRAIN.
    - imem_ready=1: discard the word, go to FETCH. If branch_taken=1 in the same cycle, the new target is still taken.
- Priority: rst > branch_taken > freeze > imem_ready.
- Latency: best-case throughput is 1 instruction/cycle with zero-wait memory. Request-to-delivery is combinational in the ready cycle.
- After a branch, the first target instruction is delivered no earlier than the cycle after branch_taken.
- A freeze lasting N cycles with a word already captured delivers that word in the first cycle freeze=0. No refetch occurs.
- branch_addr is used unmodified; no alignment check.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait memory returning addr^32'hA5A5_0000 → after release, deliveries on consecutive cycles:
  - pc_out=0x104, instruction_out=0xA5A5_0100
  - then pc_out=0x108, …
  - imem_addr sequence 0x100, 0x104, 0x108.
- Memory with 3-cycle wait on 0x0 → imem_req=1 and imem_addr=0 held for 3 cycles, bubbles (if_valid=0, outputs 0), then one delivery with pc_out=4.
- freeze=1 asserted in the imem_ready cycle at addr 0x8 and held 4 cycles → state HOLD, imem_req=0. The 0x8 word is delivered with pc_out=0xC on the first freeze=0 cycle, and the next imem_addr is 0xC.
- branch_taken=1, branch_addr=0x400 while waiting on 0x10 (ready 2 cycles later) → flush_out=1 for 1 cycle; imem_addr stays 0x10 until ready; that word is not delivered; next imem_addr=0x400; first delivery has pc_out=0x404.
- branch_taken and freeze both high in HOLD with ibuf loaded → ibuf dropped, flush_out=1, next imem_addr=branch_addr.
- rst pulsed mid-DRAIN → all outputs 0 immediately; after release, imem_addr=RESET_PC.
- Wrap check: pc at 32'hFFFF_FFFC delivering → pc_out=0 and next imem_addr=0.
